// File: rtl/exp_scale_mult_if.sv
// Operand/result handshake bundle for the e^x scale multiplier.
// The master drives the operands and out_ready; the slave returns in_ready and the result.
interface exp_scale_mult_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] exp_scale;
  logic [WIDTH-1:0] exp_frac;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] exp_out;
  logic             sat;

  modport master (
    output in_valid, exp_scale, exp_frac, out_ready,
    input  in_ready, out_valid, exp_out, sat
  );

  modport slave (
    input  in_valid, exp_scale, exp_frac, out_ready,
    output in_ready, out_valid, exp_out, sat
  );
endinterface

// File: rtl/exp_scale_mult.sv
// e^x = e^int * e^frac via shift-add multiply, round half-up, saturate; result WIDTH cycles after accept.
// Accepts only in IDLE; holds the result stable in DONE until out_ready, so one op per WIDTH+2 cycles.
module exp_scale_mult #(
  parameter int               WIDTH   = 12,
  parameter int               FRAC    = 8,
  parameter logic [WIDTH-1:0] SAT_MAX = 12'h7FF
) (
  input  logic              clk,
  input  logic              rst_n,
  exp_scale_mult_if.slave   bus
);
  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [AW:0]   HALF_LSB = (AW+1)'(1) << (FRAC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_acc;
  logic [AW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_exp_out;
  logic             r_sat;

  logic [AW-1:0]    w_acc_nxt;
  logic [AW:0]      w_rnd;
  logic             w_sat;

  // Finalize uses the accumulator including the last iteration's partial product.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_rnd     = ({1'b0, w_acc_nxt} + HALF_LSB) >> FRAC;
  assign w_sat     = (w_rnd > (AW+1)'(SAT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_exp_out   <= '0;
      r_sat       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.exp_scale};
            r_mplier <= bus.exp_frac;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_exp_out   <= w_sat ? SAT_MAX : w_rnd[WIDTH-1:0];
            r_sat       <= w_sat;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.exp_out   = r_exp_out;
  assign bus.sat       = r_sat;
endmodule

// File: tb/tb_exp_scale_mult.sv
// Directed bench for exp_scale_mult: vector table plus backpressure, reset and throughput sequences.
module tb_exp_scale_mult;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  exp_scale_mult_if #(.WIDTH(12)) bus ();

  exp_scale_mult #(.WIDTH(12), .FRAC(8), .SAT_MAX(12'h7FF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] scale;
    logic [11:0] frac;
    logic [11:0] exp_out;
    logic        sat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Accept one op with out_ready high and check latency, value and return to IDLE.
  task automatic run_op(input logic [11:0] s, input logic [11:0] f,
                        input logic [11:0] e, input logic es, input string nm);
    int k;
    bus.exp_scale = s;
    bus.exp_frac  = f;
    bus.out_ready = 1'b1;
    chk({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_latency"}, k, 32'd12);
    chk({nm, "_exp_out"}, {20'd0, bus.exp_out}, {20'd0, e});
    chk({nm, "_sat"}, {31'd0, bus.sat}, {31'd0, es});
    @(posedge clk); #1;
    chk({nm, "_out_valid_clr"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;
    int last;
    int nres;

    n_chk  = 0;
    n_fail = 0;
    vecs[0]  = '{12'h100, 12'h100, 12'h100, 1'b0};
    vecs[1]  = '{12'h2B8, 12'h180, 12'h414, 1'b0};
    vecs[2]  = '{12'h101, 12'h180, 12'h182, 1'b0};
    vecs[3]  = '{12'h7FF, 12'h2B8, 12'h7FF, 1'b1};
    vecs[4]  = '{12'h764, 12'h100, 12'h764, 1'b0};
    vecs[5]  = '{12'h7FF, 12'h100, 12'h7FF, 1'b0};
    vecs[6]  = '{12'h800, 12'h100, 12'h7FF, 1'b1};
    vecs[7]  = '{12'h000, 12'hFFF, 12'h000, 1'b0};
    vecs[8]  = '{12'h101, 12'h140, 12'h141, 1'b0};
    vecs[9]  = '{12'hFFF, 12'hFFF, 12'h7FF, 1'b1};
    vecs[10] = '{12'h001, 12'h080, 12'h001, 1'b0};
    vecs[11] = '{12'h001, 12'h07F, 12'h000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.exp_scale = '0;
    bus.exp_frac  = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_exp_out", {20'd0, bus.exp_out}, 32'd0);
    chk("rst_sat", {31'd0, bus.sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].scale, vecs[i].frac, vecs[i].exp_out, vecs[i].sat, $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while out_ready is low; a new request is ignored.
    bus.out_ready = 1'b0;
    bus.exp_scale = 12'h101;
    bus.exp_frac  = 12'h180;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_latency", k, 32'd12);
    chk("bp_exp_out", {20'd0, bus.exp_out}, 32'h182);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.exp_scale = 12'h7FF;
        bus.exp_frac  = 12'h2B8;
        bus.in_valid  = 1'b1;
      end
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_exp_out", i), {20'd0, bus.exp_out}, 32'h182);
      chk($sformatf("bp_hold%0d_sat", i), {31'd0, bus.sat}, 32'd0);
      chk($sformatf("bp_hold%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    run_op(12'h764, 12'h100, 12'h764, 1'b0, "bp_next");

    // Async reset mid-CALC discards the operation.
    bus.exp_scale = 12'hFFF;
    bus.exp_frac  = 12'hFFF;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("arst_no_stale_result", seen, 32'd0);
    chk("arst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back with in_valid and out_ready held high: one result every 14 cycles.
    bus.exp_scale = 12'h2B8;
    bus.exp_frac  = 12'h180;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    last = -1;
    nres = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        chk($sformatf("b2b%0d_exp_out", nres), {20'd0, bus.exp_out}, 32'h414);
        if (last >= 0) chk($sformatf("b2b%0d_spacing", nres), c - last, 32'd14);
        last = c;
        nres++;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_result_count", nres, 32'd4);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_drain_in_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
